// File: rtl/vec_norm_if.sv
// Operand/result handshake bundle for the iterative vector-norm engine.
interface vec_norm_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic         mode;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic [W-1:0] z;
  logic         out_valid;
  logic         out_ready;
  logic [W:0]   result;
  logic         busy;

  modport master (
    output in_valid, mode, x, y, z, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, mode, x, y, z, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/vec_norm_iter.sv
// Iterative integer Euclidean norm: shift-add squaring then restoring digit-by-digit sqrt.
// Optional VEC_NORM_ROUND_EN rounds the root to nearest instead of truncating.
module vec_norm_iter #(
  parameter int W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  vec_norm_if.slave   bus
);
  localparam int SW = 2*W + 2;
  localparam int CW = $clog2(W + 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    SQRT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e        state_q;
  logic [W-1:0]  y_q;
  logic [W-1:0]  z_q;
  logic          mode_q;
  logic [SW-1:0] mcand_q;
  logic [W-1:0]  mplier_q;
  logic [SW-1:0] acc_q;
  logic [SW-1:0] rem_q;
  logic [W:0]    root_q;
  logic [CW-1:0] cnt_q;
  logic [1:0]    opnd_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;
  logic [W:0]    result_q;

  logic [SW-1:0] acc_d;
  logic [SW+1:0] rem_shift_s;
  logic [SW+1:0] trial_s;
  logic [SW+1:0] rem_d;
  logic          root_bit_s;
  logic [W:0]    root_d;
  logic [W:0]    result_d;
  logic [W-1:0]  next_opnd_s;
  logic          last_opnd_s;

  // Multiplier step, sqrt trial subtraction and operand sequencing.
  always_comb begin
    acc_d       = acc_q;
    rem_shift_s = {rem_q, acc_q[SW-1 -: 2]};
    trial_s     = {{(SW-W-1){1'b0}}, root_q, 2'b01};
    rem_d       = rem_shift_s;
    root_bit_s  = 1'b0;
    next_opnd_s = y_q;
    last_opnd_s = 1'b0;

    if (mplier_q[0]) begin
      acc_d = acc_q + mcand_q;
    end else begin
      acc_d = acc_q;
    end

    // The accumulator top pair feeds the remainder as acc_q shifts left in SQRT.
    if (rem_shift_s >= trial_s) begin
      rem_d      = rem_shift_s - trial_s;
      root_bit_s = 1'b1;
    end else begin
      rem_d      = rem_shift_s;
      root_bit_s = 1'b0;
    end
    root_d = {root_q[W-1:0], root_bit_s};

    if (opnd_q == 2'd0) begin
      next_opnd_s = y_q;
    end else begin
      next_opnd_s = z_q;
    end

    if (mode_q) begin
      last_opnd_s = (opnd_q == 2'd2);
    end else begin
      last_opnd_s = (opnd_q == 2'd1);
    end

`ifdef VEC_NORM_ROUND_EN
    if (rem_d > {{(SW-W){1'b0}}, root_d}) begin
      result_d = root_d + {{W{1'b0}}, 1'b1};
    end else begin
      result_d = root_d;
    end
`else
    result_d = root_d;
`endif
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      y_q         <= '0;
      z_q         <= '0;
      mode_q      <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      rem_q       <= '0;
      root_q      <= '0;
      cnt_q       <= '0;
      opnd_q      <= 2'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            y_q        <= bus.y;
            z_q        <= bus.z;
            mode_q     <= bus.mode;
            mcand_q    <= {{(SW-W){1'b0}}, bus.x};
            mplier_q   <= bus.x;
            acc_q      <= '0;
            rem_q      <= '0;
            root_q     <= '0;
            cnt_q      <= '0;
            opnd_q     <= 2'd0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= SQ;
          end else begin
            state_q <= IDLE;
          end
        end
        SQ: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CW'(W-1)) begin
            cnt_q <= '0;
            if (last_opnd_s) begin
              state_q <= SQRT;
            end else begin
              opnd_q   <= opnd_q + 2'd1;
              mcand_q  <= {{(SW-W){1'b0}}, next_opnd_s};
              mplier_q <= next_opnd_s;
            end
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SQRT: begin
          acc_q  <= acc_q << 2;
          rem_q  <= rem_d[SW-1:0];
          root_q <= root_d;
          if (cnt_q == CW'(W)) begin
            cnt_q       <= '0;
            result_q    <= result_d;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end else begin
            state_q <= DONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.result    = result_q;
endmodule

// File: tb/tb_vec_norm_iter.sv
// Directed and randomized checks of vec_norm_iter (W=8) against an arithmetic norm model.
module tb_vec_norm_iter;
  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  vec_norm_if #(.W(W)) bus();

  vec_norm_iter #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain arithmetic norm: smallest-r search on the sum of squares.
  function automatic int norm_model(input logic m, input int a, input int b, input int c);
    longint s;
    longint r;
    s = longint'(a) * a + longint'(b) * b;
    if (m) s = s + longint'(c) * c;
    r = 0;
    while ((r + 1) * (r + 1) <= s) r = r + 1;
`ifdef VEC_NORM_ROUND_EN
    if (4 * s >= (2 * r + 1) * (2 * r + 1)) r = r + 1;
`endif
    return int'(r);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offer one operand set, count edges to out_valid, optionally stall, then handshake.
  task automatic do_op(input string tag, input logic m, input int a, input int b, input int c,
                       input int exp_r, input int stall);
    int   lat;
    int   exp_l;
    logic hold_ok;
    logic [W:0] held;
    exp_l = (m ? 3 : 2) * W + W + 1;
    check({tag, " in_ready idle"}, 32'(bus.in_ready), 32'd1);
    bus.mode     = m;
    bus.x        = W'(a);
    bus.y        = W'(b);
    bus.z        = W'(c);
    bus.in_valid = 1'b1;
    bus.out_ready = (stall == 0);
    @(posedge clk); #1;
    lat = 0;
    hold_ok = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) hold_ok = 1'b0;
      bus.in_valid = 1'($urandom_range(1, 0));
      bus.x = W'($urandom);
      bus.y = W'($urandom);
      bus.z = W'($urandom);
      bus.mode = 1'($urandom_range(1, 0));
      @(posedge clk); #1;
      lat++;
    end
    bus.in_valid = 1'b0;
    check({tag, " busy/in_ready during op"}, 32'(hold_ok), 32'd1);
    check({tag, " latency"}, 32'(lat), 32'(exp_l));
    check({tag, " result"}, 32'(bus.result), 32'(exp_r));
    if (stall > 0) begin
      held = bus.result;
      hold_ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        bus.in_valid = 1'b1;
        bus.x = W'($urandom);
        @(posedge clk); #1;
        if (bus.out_valid !== 1'b1 || bus.result !== held || bus.in_ready !== 1'b0)
          hold_ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      check({tag, " stable under backpressure"}, 32'(hold_ok), 32'd1);
      bus.out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, " out_valid after handshake"}, 32'(bus.out_valid), 32'd0);
    check({tag, " in_ready after handshake"}, 32'(bus.in_ready), 32'd1);
    check({tag, " busy after handshake"}, 32'(bus.busy), 32'd0);
    check({tag, " result kept"}, 32'(bus.result), 32'(exp_r));
  endtask

  initial begin
    int a;
    int b;
    int c;
    logic m;
    checks = 0;
    errors = 0;
    bus.in_valid  = 1'b0;
    bus.mode      = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.z         = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset result", 32'(bus.result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("2d 3,4", 1'b0, 3, 4, 0, 5, 0);
    do_op("3d 2,3,6", 1'b1, 2, 3, 6, 7, 0);
    do_op("2d z ignored", 1'b0, 6, 8, 200, 10, 0);
`ifdef VEC_NORM_ROUND_EN
    do_op("2d max", 1'b0, 255, 255, 0, 361, 0);
    do_op("3d max", 1'b1, 255, 255, 255, 442, 0);
`else
    do_op("2d max", 1'b0, 255, 255, 0, 360, 0);
    do_op("3d max", 1'b1, 255, 255, 255, 441, 0);
`endif
    do_op("2d zero", 1'b0, 0, 0, 0, 0, 0);
    do_op("3d zero", 1'b1, 0, 0, 0, 0, 0);
    do_op("backpressure", 1'b1, 1, 2, 2, 3, 10);
    do_op("after backpressure", 1'b0, 5, 12, 0, 13, 0);

    // Abort a 3D operation mid-flight.
    bus.mode = 1'b1; bus.x = 8'd9; bus.y = 8'd9; bus.z = 8'd9;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop reset out_valid", 32'(bus.out_valid), 32'd0);
    check("midop reset result", 32'(bus.result), 32'd0);
    check("midop reset in_ready", 32'(bus.in_ready), 32'd1);
    check("midop reset busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("post reset 3,4", 1'b0, 3, 4, 0, 5, 0);

    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom_range(1, 0));
      a = int'($urandom_range(255, 0));
      b = int'($urandom_range(255, 0));
      c = int'($urandom_range(255, 0));
      do_op("random", m, a, b, c, norm_model(m, a, b, c), (i % 5 == 4) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
